// File: rtl/retire_trace_buffer.sv
// Retirement trace stage: classifies each retiring instruction, tags it with a sequence number and queues it.
// Latency: a record is written on the retire edge and is visible at the FIFO head the following cycle.
// Backpressure: rec_ready low holds the head stable; a retire into a full, non-popping FIFO is dropped and counted.

// Generic FIFO: head is read combinationally from storage; the occupancy counter is one bit wider than the pointers.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: caller must only push when not full (or when popping that cycle) and only pop when not empty.
module traceFifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] headData,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W:0]   count;

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    // A push into a full FIFO with a simultaneous pop overwrites the slot being popped,
    // which is safe because the head is read before the edge.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr] <= pushData;
        end
    end

    assign headData = mem[rdPtr];
    assign empty    = (count == '0);
    assign full     = (count == (PTR_W+1)'(DEPTH));

endmodule

module retire_trace_buffer #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        retire_valid,
    input  logic [15:0] ret_pc,
    input  logic        ret_regwrite,
    input  logic [2:0]  ret_wreg,
    input  logic [15:0] ret_wdata,
    input  logic        ret_memread,
    input  logic        ret_memwrite,
    input  logic [15:0] ret_memaddr,
    input  logic [15:0] ret_memdata,
    input  logic        ret_halt,
    output logic        rec_valid,
    input  logic        rec_ready,
    output logic [2:0]  rec_type,
    output logic [15:0] rec_inum,
    output logic [15:0] rec_pc,
    output logic [2:0]  rec_reg,
    output logic [15:0] rec_rdata,
    output logic [15:0] rec_addr,
    output logic [15:0] rec_mdata,
    output logic [15:0] inst_count,
    output logic [15:0] cycle_count,
    output logic        halted,
    output logic        overflow,
    output logic [7:0]  drop_count
);

    localparam logic [2:0] TYPE_NOP      = 3'd0;
    localparam logic [2:0] TYPE_REG      = 3'd1;
    localparam logic [2:0] TYPE_LOAD     = 3'd2;
    localparam logic [2:0] TYPE_STORE    = 3'd3;
    localparam logic [2:0] TYPE_STOREUPD = 3'd4;
    localparam logic [2:0] TYPE_HALT     = 3'd5;

    typedef struct packed {
        logic [2:0]  recType;
        logic [15:0] inum;
        logic [15:0] pc;
        logic [2:0]  regNum;
        logic [15:0] rdata;
        logic [15:0] addr;
        logic [15:0] mdata;
    } traceRec_t;

    traceRec_t newRec;
    traceRec_t headRec;
    traceRec_t outRec;

    logic retireEvt;
    logic popReq;
    logic pushReq;
    logic dropEvt;
    logic fifoEmpty;
    logic fifoFull;

    // Fields that carry no meaning for the record type are left at zero.
    always_comb begin
        newRec      = '0;
        newRec.inum = inst_count;
        newRec.pc   = ret_pc;
        if (ret_halt) begin
            newRec.recType = TYPE_HALT;
        end else if (ret_regwrite && ret_memwrite) begin
            newRec.recType = TYPE_STOREUPD;
            newRec.regNum  = ret_wreg;
            newRec.rdata   = ret_wdata;
            newRec.addr    = ret_memaddr;
            newRec.mdata   = ret_memdata;
        end else if (ret_regwrite && ret_memread) begin
            newRec.recType = TYPE_LOAD;
            newRec.regNum  = ret_wreg;
            newRec.rdata   = ret_wdata;
            newRec.addr    = ret_memaddr;
        end else if (ret_regwrite) begin
            newRec.recType = TYPE_REG;
            newRec.regNum  = ret_wreg;
            newRec.rdata   = ret_wdata;
        end else if (ret_memwrite) begin
            newRec.recType = TYPE_STORE;
            newRec.addr    = ret_memaddr;
            newRec.mdata   = ret_memdata;
        end else begin
            newRec.recType = TYPE_NOP;
        end
    end

    assign retireEvt = retire_valid && !halted;
    assign popReq    = !fifoEmpty && rec_ready;
    assign pushReq   = retireEvt && (!fifoFull || popReq);
    assign dropEvt   = retireEvt && fifoFull && !popReq;

    traceFifo #(
        .WIDTH($bits(traceRec_t)),
        .DEPTH(DEPTH),
        .PTR_W(PTR_W)
    ) recFifo (
        .clk      (clk),
        .rst      (rst),
        .push     (pushReq),
        .pushData (newRec),
        .pop      (popReq),
        .headData (headRec),
        .empty    (fifoEmpty),
        .full     (fifoFull)
    );

    // Stale storage is never exposed: an empty FIFO presents an all-zero record.
    assign outRec    = fifoEmpty ? '0 : headRec;
    assign rec_valid = !fifoEmpty;
    assign rec_type  = outRec.recType;
    assign rec_inum  = outRec.inum;
    assign rec_pc    = outRec.pc;
    assign rec_reg   = outRec.regNum;
    assign rec_rdata = outRec.rdata;
    assign rec_addr  = outRec.addr;
    assign rec_mdata = outRec.mdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            inst_count  <= '0;
            cycle_count <= '0;
            halted      <= 1'b0;
            overflow    <= 1'b0;
            drop_count  <= '0;
        end else begin
            if (!halted) begin
                cycle_count <= cycle_count + 16'd1;
            end
            // A dropped record still counts as retired, and a dropped halt still stops the trace.
            if (retireEvt) begin
                inst_count <= inst_count + 16'd1;
                if (ret_halt) begin
                    halted <= 1'b1;
                end
            end
            if (dropEvt) begin
                overflow <= 1'b1;
                if (drop_count != 8'hFF) begin
                    drop_count <= drop_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Randomized plus directed bench for retire_trace_buffer with a queue-based reference model and scoreboard.
module tb_retire_trace_buffer;

    localparam int DEPTH = 8;
    localparam int PTR_W = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        retire_valid;
    logic [15:0] ret_pc;
    logic        ret_regwrite;
    logic [2:0]  ret_wreg;
    logic [15:0] ret_wdata;
    logic        ret_memread;
    logic        ret_memwrite;
    logic [15:0] ret_memaddr;
    logic [15:0] ret_memdata;
    logic        ret_halt;
    logic        rec_valid;
    logic        rec_ready;
    logic [2:0]  rec_type;
    logic [15:0] rec_inum;
    logic [15:0] rec_pc;
    logic [2:0]  rec_reg;
    logic [15:0] rec_rdata;
    logic [15:0] rec_addr;
    logic [15:0] rec_mdata;
    logic [15:0] inst_count;
    logic [15:0] cycle_count;
    logic        halted;
    logic        overflow;
    logic [7:0]  drop_count;

    always #5 clk = ~clk;

    retire_trace_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .rst(rst), .retire_valid(retire_valid), .ret_pc(ret_pc),
        .ret_regwrite(ret_regwrite), .ret_wreg(ret_wreg), .ret_wdata(ret_wdata),
        .ret_memread(ret_memread), .ret_memwrite(ret_memwrite), .ret_memaddr(ret_memaddr),
        .ret_memdata(ret_memdata), .ret_halt(ret_halt), .rec_valid(rec_valid),
        .rec_ready(rec_ready), .rec_type(rec_type), .rec_inum(rec_inum), .rec_pc(rec_pc),
        .rec_reg(rec_reg), .rec_rdata(rec_rdata), .rec_addr(rec_addr), .rec_mdata(rec_mdata),
        .inst_count(inst_count), .cycle_count(cycle_count), .halted(halted),
        .overflow(overflow), .drop_count(drop_count)
    );

    typedef struct packed {
        logic [2:0]  t;
        logic [15:0] inum;
        logic [15:0] pc;
        logic [2:0]  r;
        logic [15:0] rdata;
        logic [15:0] addr;
        logic [15:0] mdata;
    } rec_t;

    rec_t        expQ[$];
    int          mOcc;
    int unsigned mInst, mCycle, mDrop;
    bit          mHalted, mOverflow;
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected record from the classification table, built from the currently applied inputs.
    function automatic rec_t expectRec(input logic [15:0] inum);
        rec_t r;
        r = '0;
        r.inum = inum;
        r.pc   = ret_pc;
        if (ret_halt)                          r.t = 3'd5;
        else if (ret_regwrite && ret_memwrite) r.t = 3'd4;
        else if (ret_regwrite && ret_memread)  r.t = 3'd2;
        else if (ret_regwrite)                 r.t = 3'd1;
        else if (ret_memwrite)                 r.t = 3'd3;
        else                                   r.t = 3'd0;
        if (r.t == 3'd1 || r.t == 3'd2 || r.t == 3'd4) begin
            r.r     = ret_wreg;
            r.rdata = ret_wdata;
        end
        if (r.t == 3'd2 || r.t == 3'd3 || r.t == 3'd4) r.addr  = ret_memaddr;
        if (r.t == 3'd3 || r.t == 3'd4)                r.mdata = ret_memdata;
        return r;
    endfunction

    // Reference model: updates on each edge from the inputs applied during the preceding cycle.
    always @(posedge clk) begin
        bit popNow;
        if (rst) begin
            expQ.delete();
            mOcc = 0; mInst = 0; mCycle = 0; mDrop = 0;
            mHalted = 0; mOverflow = 0;
        end else begin
            popNow = (mOcc > 0) && rec_ready;
            if (!mHalted) mCycle = (mCycle + 1) % 65536;
            if (popNow) mOcc--;
            if (retire_valid && !mHalted) begin
                if (mOcc < DEPTH) begin
                    expQ.push_back(expectRec(16'(mInst)));
                    mOcc++;
                end else begin
                    mOverflow = 1;
                    if (mDrop < 255) mDrop++;
                end
                mInst = (mInst + 1) % 65536;
                if (ret_halt) mHalted = 1;
            end
        end
    end

    // Monitor: compares the presented head against the scoreboard and pops on handshake.
    always @(negedge clk) begin
        check("rec_valid", rec_valid, mOcc > 0);
        if (rec_valid) begin
            if (expQ.size() == 0) begin
                check("unexpected record", 1'b1, 1'b0);
            end else begin
                check("head record", {rec_type, rec_inum, rec_pc, rec_reg, rec_rdata, rec_addr, rec_mdata}, expQ[0]);
                if (rec_ready && !rst) void'(expQ.pop_front());
            end
        end else begin
            check("empty data zero", {rec_type, rec_inum, rec_pc, rec_reg, rec_rdata, rec_addr, rec_mdata}, '0);
        end
        check("inst_count", inst_count, 16'(mInst));
        check("cycle_count", cycle_count, 16'(mCycle));
        check("halted", halted, mHalted);
        check("overflow", overflow, mOverflow);
        check("drop_count", drop_count, 8'(mDrop));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        retire_valid = 0; ret_pc = '0; ret_regwrite = 0; ret_wreg = '0; ret_wdata = '0;
        ret_memread = 0; ret_memwrite = 0; ret_memaddr = '0; ret_memdata = '0; ret_halt = 0;
    endtask

    task automatic randFields(input bit allowHalt);
        ret_pc       = 16'($urandom);
        ret_regwrite = 1'($urandom);
        ret_wreg     = 3'($urandom);
        ret_wdata    = 16'($urandom);
        ret_memread  = 1'($urandom);
        ret_memwrite = 1'($urandom);
        ret_memaddr  = 16'($urandom);
        ret_memdata  = 16'($urandom);
        ret_halt     = allowHalt && ($urandom_range(0, 299) == 0);
    endtask

    task automatic doReset();
        idle();
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    task automatic drain();
        rec_ready = 1;
        retire_valid = 0;
        for (int i = 0; i < 4 * DEPTH && rec_valid; i++) step();
        check("drain completes", rec_valid, 1'b0);
    endtask

    initial begin
        rec_ready = 0;
        doReset();
        check("reset rec_valid", rec_valid, 1'b0);
        check("reset inst_count", inst_count, 16'd0);
        check("reset halted", halted, 1'b0);
        check("reset drop_count", drop_count, 8'd0);

        // Single register-write retire.
        retire_valid = 1; ret_regwrite = 1; ret_wreg = 3'd3; ret_wdata = 16'h1234; ret_pc = 16'h0002;
        step();
        idle();
        check("t1 rec_valid", rec_valid, 1'b1);
        check("t1 type", rec_type, 3'd1);
        check("t1 inum", rec_inum, 16'd0);
        check("t1 reg", rec_reg, 3'd3);
        check("t1 rdata", rec_rdata, 16'h1234);
        check("t1 inst_count", inst_count, 16'd1);
        rec_ready = 1;
        step();
        rec_ready = 0;

        // Store-update, then a nop retiring while the store-update pops.
        retire_valid = 1; ret_regwrite = 1; ret_memwrite = 1; ret_memaddr = 16'h0040;
        ret_memdata = 16'hBEEF; ret_wreg = 3'd5; ret_wdata = 16'h00AA; ret_pc = 16'h0004;
        step();
        idle();
        check("t2 type", rec_type, 3'd4);
        check("t2 addr", rec_addr, 16'h0040);
        check("t2 mdata", rec_mdata, 16'hBEEF);
        check("t2 reg", rec_reg, 3'd5);
        retire_valid = 1; ret_pc = 16'h0006; rec_ready = 1;
        step();
        idle();
        rec_ready = 0;
        check("t2 nop type", rec_type, 3'd0);
        check("t2 nop inum", rec_inum, 16'd2);
        check("t2 nop zero", {rec_reg, rec_rdata, rec_addr, rec_mdata}, '0);
        drain();

        // Overflow with the consumer stalled.
        doReset();
        rec_ready = 0;
        for (int i = 0; i < 10; i++) begin
            retire_valid = 1;
            randFields(0);
            step();
        end
        idle();
        check("t3 overflow", overflow, 1'b1);
        check("t3 drop_count", drop_count, 8'd2);
        check("t3 inst_count", inst_count, 16'd10);
        check("t3 head inum", rec_inum, 16'd0);

        // Full FIFO with a simultaneous pop accepts the push.
        retire_valid = 1; randFields(0); rec_ready = 1;
        step();
        idle(); rec_ready = 0;
        check("t4 no drop", drop_count, 8'd2);
        check("t4 head advanced", rec_inum, 16'd1);
        retire_valid = 1; randFields(0);
        step();
        idle();
        check("t4 still full", drop_count, 8'd3);
        drain();

        // Halt at cycle_count 20, followed by ignored retires.
        doReset();
        rec_ready = 1;
        for (int i = 0; i < 40 && cycle_count != 16'd20; i++) step();
        rec_ready = 0;
        retire_valid = 1; ret_halt = 1; ret_regwrite = 1; ret_wdata = 16'h5555; ret_pc = 16'h0100;
        step();
        idle();
        check("t5 type", rec_type, 3'd5);
        check("t5 halt zero", {rec_reg, rec_rdata, rec_addr, rec_mdata}, '0);
        check("t5 halted", halted, 1'b1);
        check("t5 cycle frozen", cycle_count, 16'd21);
        for (int i = 0; i < 3; i++) begin
            retire_valid = 1; randFields(0);
            step();
        end
        idle();
        check("t5 inst frozen", inst_count, 16'd1);
        check("t5 cycle still", cycle_count, 16'd21);
        drain();

        // Reset with records queued.
        doReset();
        rec_ready = 0;
        for (int i = 0; i < 4; i++) begin
            retire_valid = 1; randFields(0);
            step();
        end
        idle();
        rst = 1;
        step();
        rst = 0;
        check("t6 rec_valid", rec_valid, 1'b0);
        check("t6 inst_count", inst_count, 16'd0);
        check("t6 cycle_count", cycle_count, 16'd0);
        retire_valid = 1; randFields(0);
        step();
        idle();
        check("t6 inum", rec_inum, 16'd0);
        drain();

        // Drop counter saturation.
        doReset();
        rec_ready = 0;
        for (int i = 0; i < 270; i++) begin
            retire_valid = 1; randFields(0);
            step();
        end
        idle();
        check("sat drop_count", drop_count, 8'hFF);
        check("sat inst_count", inst_count, 16'd270);
        drain();

        // Random traffic with occasional halts and resets.
        doReset();
        for (int i = 0; i < 4000; i++) begin
            retire_valid = ($urandom_range(0, 99) < 60);
            randFields(1);
            rec_ready = ($urandom_range(0, 99) < ((i / 500) % 2 ? 80 : 30));
            rst = ($urandom_range(0, 399) == 0);
            step();
        end
        idle();
        rst = 0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
